// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data memory responder: RV32I opcodes, load/store funct3 codes,
// access sizes and the responder FSM states.
package data_memory_responder_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MAX_WAIT_CYCLES = 15;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between a core's data port and the data memory responder.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_address, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_address, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_responder_aligner.sv
// load_store_aligner: combinational byte-enable, store-lane replication and load extension
// for RV32I byte/halfword/word accesses; also flags illegal funct3 and misalignment.
module load_store_aligner
  import data_memory_responder_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data,
  output logic        illegal,
  output logic        misaligned
);

  size_e       size;
  logic        sign_ext;
  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    size     = SIZE_WORD;
    sign_ext = 1'b0;
    illegal  = 1'b0;
    unique case (funct3)
      F3_B:    begin size = SIZE_BYTE; sign_ext = !write; end
      F3_H:    begin size = SIZE_HALF; sign_ext = !write; end
      F3_W:    size = SIZE_WORD;
      F3_BU:   if (write) illegal = 1'b1; else size = SIZE_BYTE;
      F3_HU:   if (write) illegal = 1'b1; else size = SIZE_HALF;
      default: illegal = 1'b1;
    endcase
  end

  // Misaligned halfwords/words are aligned down by picking the lane from the upper offset bits only.
  always_comb begin
    lane       = 2'd0;
    byte_en    = 4'b1111;
    lane_wdata = store_data;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        lane       = byte_offset;
        byte_en    = 4'b0001 << byte_offset;
        lane_wdata = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        lane       = {byte_offset[1], 1'b0};
        byte_en    = byte_offset[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
        misaligned = byte_offset[0];
      end
      default: misaligned = (byte_offset != 2'd0);
    endcase
  end

  assign shifted = mem_word >> {lane, 3'b000};

  always_comb begin
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: one request at a time, WAIT_CYCLES wait states, byte-lane RAM.
// Optional access-fault checking is enabled by defining DMEM_ERROR_EN.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  data_memory_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic        armed_reg;
  logic        write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        err_reg;

  logic        handshake, enter_resp, err_now, mem_we, mem_re;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_funct3;
  logic [AW-1:0] word_idx;
  logic [3:0]  byte_en;
  logic [31:0] lane_wdata, load_data, mem_word;
  logic        illegal, misaligned;

  assign bus.req_ready = armed_reg && (state_reg == IDLE);
  assign handshake     = bus.req_valid && bus.req_ready;

  // With zero wait states the RAM is accessed on the handshake edge itself, so use the live bus there.
  assign acc_write  = (state_reg == IDLE) ? bus.req_write   : write_reg;
  assign acc_addr   = (state_reg == IDLE) ? bus.req_address : addr_reg;
  assign acc_wdata  = (state_reg == IDLE) ? bus.req_wdata   : wdata_reg;
  assign acc_funct3 = (state_reg == IDLE) ? bus.req_funct3  : funct3_reg;
  assign word_idx   = acc_addr[AW+1:2];

  load_store_aligner u_aligner (
    .write       (acc_write),
    .funct3      (acc_funct3),
    .byte_offset (acc_addr[1:0]),
    .store_data  (acc_wdata),
    .mem_word    (mem_word),
    .byte_en     (byte_en),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data),
    .illegal     (illegal),
    .misaligned  (misaligned)
  );

`ifdef DMEM_ERROR_EN
  assign err_now = illegal || misaligned || (acc_addr[31:AW+2] != '0);
`else
  logic unused_bits;
  assign err_now     = 1'b0;
  assign unused_bits = ^{illegal, misaligned, acc_addr[31:AW+2]};
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            count_next = 4'(WAIT_CYCLES - 1);
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (count_reg == 4'd0) state_next = RESP;
        else                   count_next = count_reg - 4'd1;
      end
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP) && (state_reg != RESP);
  assign mem_we     = enter_resp && acc_write && !err_now;
  assign mem_re     = enter_resp && !acc_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= 4'd0;
      armed_reg  <= 1'b0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      funct3_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      armed_reg <= 1'b1;
      if (handshake) begin
        write_reg  <= bus.req_write;
        addr_reg   <= bus.req_address;
        wdata_reg  <= bus.req_wdata;
        funct3_reg <= bus.req_funct3;
      end
      if (enter_resp) err_reg <= err_now;
    end
  end

  // One byte-wide RAM per lane; contents survive reset.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q;
      always_ff @(posedge clock) begin
        if (mem_we && byte_en[gi]) lane_mem[word_idx] <= lane_wdata[gi*8 +: 8];
        if (mem_re)                lane_q <= lane_mem[word_idx];
      end
      assign mem_word[gi*8 +: 8] = lane_q;
    end
  endgenerate

  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_error = bus.rsp_valid && err_reg;
  assign bus.rsp_rdata = (bus.rsp_valid && !write_reg && !err_reg) ? load_data : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (WAIT_CYCLES=2); build with
// DMEM_ERROR_EN defined to exercise the fault-checking variant.
module tb_data_memory_responder;

  localparam int WAITS = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  data_memory_responder_if bus();

  data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
    bus.req_write   = wr;
    bus.req_funct3  = f3;
    bus.req_address = addr;
    bus.req_wdata   = wd;
    bus.req_valid   = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 20) begin tick(); n++; end
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin tick(); lat++; end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat);
    wait_ready(tag);
    drive_req(wr, f3, addr, wd);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(tag, lat);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_error;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    $display("[TB] %s wr=%0b f3=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             tag, wr, f3, addr, wd, rdata, err, lat);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(tag, 1'b1, f3, addr, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_latency"}, 32'(lat), 32'(1 + WAITS));
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(tag, 1'b0, f3, addr, 32'd0, rd, er, lat);
    check({tag, "_rdata"}, rd, exp);
    check({tag, "_error"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    logic [31:0] rd;
    logic        er;

    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_address = '0;
    bus.req_wdata   = '0;
    bus.req_funct3  = '0;
    bus.rsp_ready   = 1'b0;

    // Reset state and release
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    reset_n = 1'b1;
    check("rel_req_ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    check("rel_req_ready_after_edge", 32'(bus.req_ready), 32'd1);

    // Word store, then sub-word loads with sign/zero extension
    do_store("sw_10", 3'b010, 32'h10, 32'hDEADBEEF);
    do_load("lw_10",  3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    do_load("lb_13",  3'b000, 32'h13, 32'hFFFFFFDE, 1'b0);
    do_load("lbu_13", 3'b100, 32'h13, 32'h000000DE, 1'b0);
    do_load("lh_10",  3'b001, 32'h10, 32'hFFFFBEEF, 1'b0);
    do_load("lhu_12", 3'b101, 32'h12, 32'h0000DEAD, 1'b0);

    do_store("sb_11", 3'b000, 32'h11, 32'h12345677);
    do_load("lw_10_after_sb", 3'b010, 32'h10, 32'hDEAD77EF, 1'b0);

    do_store("sw_20", 3'b010, 32'h20, 32'h11111111);
    do_store("sh_22", 3'b001, 32'h22, 32'h0000CAFE);
    do_load("lw_20_after_sh", 3'b010, 32'h20, 32'hCAFE1111, 1'b0);
    do_load("lb_21_pos", 3'b000, 32'h21, 32'h00000011, 1'b0);

    // Back-pressure: response held 5 cycles while a new request is ignored
    wait_ready("stall");
    drive_req(1'b0, 3'b010, 32'h10, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp("stall", lat);
    held = bus.rsp_rdata;
    check("stall_first_rdata", held, 32'hDEAD77EF);
    drive_req(1'b1, 3'b010, 32'h20, 32'h55555555);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("stall_rdata_%0d", i), bus.rsp_rdata, 32'hDEAD77EF);
      check($sformatf("stall_req_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("stall_released", 32'(bus.rsp_valid), 32'd0);
    $display("[TB] stall LW @10 held 5 cycles rdata=%h", held);
    do_load("lw_20_not_overwritten", 3'b010, 32'h20, 32'hCAFE1111, 1'b0);

    // rsp_ready already high: single-cycle rsp_valid
    bus.rsp_ready = 1'b1;
    wait_ready("fast");
    drive_req(1'b0, 3'b001, 32'h12, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp("fast", lat);
    check("fast_latency", 32'(lat), 32'(1 + WAITS));
    check("fast_rdata", bus.rsp_rdata, 32'hFFFFDEAD);
    tick();
    check("fast_valid_drops", 32'(bus.rsp_valid), 32'd0);
    check("fast_req_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b0;
    $display("[TB] fast LH @12 single-cycle response lat=%0d", lat);

`ifdef DMEM_ERROR_EN
    do_load("lw_12_misaligned", 3'b010, 32'h12, 32'd0, 1'b1);
    do_load("lh_11_misaligned", 3'b001, 32'h11, 32'd0, 1'b1);
    do_load("lw_oor", 3'b010, 32'h1010, 32'd0, 1'b1);
    access("sw_oor", 1'b1, 3'b010, 32'h1010, 32'hA5A5A5A5, rd, er, lat);
    check("sw_oor_error", 32'(er), 32'd1);
    check("sw_oor_latency", 32'(lat), 32'(1 + WAITS));
    access("sw_illegal_f3", 1'b1, 3'b011, 32'h10, 32'h0BADF00D, rd, er, lat);
    check("sw_illegal_f3_error", 32'(er), 32'd1);
    do_load("lw_10_no_store", 3'b010, 32'h10, 32'hDEAD77EF, 1'b0);
`else
    do_load("lw_12_aligned_down", 3'b010, 32'h12, 32'hDEAD77EF, 1'b0);
    do_load("lw_wrap", 3'b010, 32'h1010, 32'hDEAD77EF, 1'b0);
    do_load("lw_illegal_f3", 3'b111, 32'h20, 32'hCAFE1111, 1'b0);
`endif

    // Reset during the WAIT phase of a store aborts it
    wait_ready("rst_mid");
    drive_req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    tick();
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    check("rst_mid_valid_held", 32'(bus.rsp_valid), 32'd0);
    reset_n = 1'b1;
    check("rst_mid_ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    check("rst_mid_ready_after_edge", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_mid_no_rsp_%0d", i), 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    $display("[TB] reset during WAIT of SW @10 aborted");
    do_load("lw_10_after_abort", 3'b010, 32'h10, 32'hDEAD77EF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  core presents a request.
REQ-006 SHALL have port req_ready  out  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_address  in  32  byte address, the core's data_mem_address.
REQ-009 SHALL have port req_wdata  in  32  store data, the core's data_mem_write_data, right-justified.
REQ-010 SHALL have port req_funct3  in  3  RV32I load/store funct3 size/sign code.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  core consumes the response.
REQ-013 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_error  out  1  access faulted.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL hold req_ready high only in IDLE; req_valid && req_ready is a handshake, and it latches every req_* field.
REQ-017 SHALL go IDLE->WAIT on handshake when WAIT_CYCLES>0, else IDLE->RESP.
REQ-018 SHALL stay in WAIT exactly WAIT_CYCLES cycles, tracked by a down-counter, then go to RESP.
REQ-019 SHALL, on the edge entering RESP, commit the store byte lanes and capture the load data.
REQ-020 SHALL assert rsp_valid in RESP and hold it, with rsp_rdata/rsp_error stable, until rsp_ready; rsp_valid thus rises 1+WAIT_CYCLES cycles after the handshake.
REQ-021 SHALL return RESP->IDLE on rsp_ready; no back-to-back acceptance, one request at a time.
REQ-022 SHALL index the word as req_address[log2(DEPTH_WORDS)+1:2] and select the lane by req_address[1:0].
REQ-023 SHALL write SB (000) to one lane, SH (001) to lanes {1:0} or {3:2}, and SW (010) to all four lanes.
REQ-024 SHALL sign-extend LB (000) and LH (001) to 32 bits, zero-extend LBU (100) and LHU (101), and return LW (010) unchanged.
REQ-025 SHALL make a load issued after a store to the same address return the stored value.
REQ-026 SHALL return RESP->IDLE when rsp_ready is already high on RESP entry, giving a single-cycle rsp_valid.

Reset
REQ-027 SHALL, while reset_n is low, force state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0 and rsp_error 0.
REQ-028 SHALL raise req_ready on the first clock edge after reset_n deasserts.
REQ-029 SHALL abort an in-flight access when reset occurs mid-access, writing nothing; prior storage contents are retained and the array itself is not reset.

Configuration
REQ-030 SHALL support macro DMEM_ERROR_EN.
REQ-031 SHALL, with DMEM_ERROR_EN defined, flag as errors: a misaligned halfword (addr[0]=1), a misaligned word (addr[1:0]!=0), an address at or above 4*DEPTH_WORDS, and an illegal funct3; each then gives rsp_error=1, rsp_rdata=0, no store and unchanged latency.
REQ-032 SHALL, without DMEM_ERROR_EN, tie rsp_error to 0, treat illegal funct3 as word, align halfword/word accesses down, and wrap out-of-range addresses modulo DEPTH_WORDS.

Structure
REQ-033 SHALL place the funct3 size/sign codes and the FSM state enum in the shared constants package, next to the existing opcode constants.
REQ-034 SHALL contain one combinational sub-module, load_store_aligner, that produces byte-enables, shifted store data and extended load data.

Verification
REQ-035 SHALL test: WAIT_CYCLES=2, SW 0xDEADBEEF @0x10 -> rsp_valid 3 cycles after handshake; then LW @0x10 -> 0xDEADBEEF.
REQ-036 SHALL test: after REQ-035, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
REQ-037 SHALL test: SB 0x12345677 @0x11 over 0xDEADBEEF -> LW @0x10 -> 0xDEAD77EF.
REQ-038 SHALL test: rsp_ready held low 5 cycles -> rsp_valid and data stable for all 5, req_ready low, a new req_valid ignored.
REQ-039 SHALL test, with DMEM_ERROR_EN: LW @0x12 -> rsp_error=1, rdata 0. Without it: LW @0x12 -> the word at 0x10.
REQ-040 SHALL test: reset_n pulsed low during WAIT of a SW -> no rsp_valid, target word unchanged, req_ready=1 one edge after release.
